// File: rtl/face_marker_if.sv
// rtl/face_marker_if.sv - control, mask-pixel and annotated-pixel signal bundle for face_marker
interface face_marker_if #(
    parameter int COLOR_DEPTH = 8
);
    logic                   start;
    logic [7:0]             centroid_x;
    logic [7:0]             centroid_y;
    logic [COLOR_DEPTH-1:0] pixel_in;
    logic                   pixel_valid;
    logic [COLOR_DEPTH-1:0] out_R;
    logic [COLOR_DEPTH-1:0] out_G;
    logic [COLOR_DEPTH-1:0] out_B;
    logic                   out_valid;
    logic                   frame_done;
    logic                   busy;
    logic [7:0]             frame_count;

    modport master (
        output start, centroid_x, centroid_y, pixel_in, pixel_valid,
        input  out_R, out_G, out_B, out_valid, frame_done, busy, frame_count
    );

    modport slave (
        input  start, centroid_x, centroid_y, pixel_in, pixel_valid,
        output out_R, out_G, out_B, out_valid, frame_done, busy, frame_count
    );
endinterface

// File: rtl/face_marker.sv
// rtl/face_marker.sv - overlays a green centroid dot and red box outline on a raster mask stream
module face_marker #(
    parameter int WIDTH       = 256,
    parameter int DEPTH       = 256,
    parameter int COLOR_DEPTH = 8,
    parameter int MARK_HALF   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    face_marker_if.slave  bus
);
    localparam logic [8:0] XMAX = 9'(WIDTH - 1);
    localparam logic [8:0] YMAX = 9'(DEPTH - 1);
    localparam logic [8:0] MH   = 9'(MARK_HALF);
    localparam logic [COLOR_DEPTH-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t     state;
    logic [8:0] cx, cy, x0, x1, y0, y1, x, y;
    logic [8:0] cx_n, cy_n, x0_n, x1_n, y0_n, y1_n;
    logic       in_x, in_y, on_center, on_outline, last_px;

    // Bounds are computed in 9 bits so cx+MARK_HALF cannot wrap before clamping.
    always_comb begin
        cx_n = ({1'b0, bus.centroid_x} > XMAX) ? XMAX : {1'b0, bus.centroid_x};
        cy_n = ({1'b0, bus.centroid_y} > YMAX) ? YMAX : {1'b0, bus.centroid_y};
        x0_n = (cx_n >= MH) ? cx_n - MH : 9'd0;
        y0_n = (cy_n >= MH) ? cy_n - MH : 9'd0;
        x1_n = ((cx_n + MH) > XMAX) ? XMAX : cx_n + MH;
        y1_n = ((cy_n + MH) > YMAX) ? YMAX : cy_n + MH;
    end

    always_comb begin
        in_x       = (x >= x0) && (x <= x1);
        in_y       = (y >= y0) && (y <= y1);
        on_center  = (x == cx) && (y == cy);
        on_outline = (((x == x0) || (x == x1)) && in_y) ||
                     (((y == y0) || (y == y1)) && in_x);
        last_px    = (x == XMAX) && (y == YMAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cx              <= '0;
            cy              <= '0;
            x0              <= '0;
            x1              <= '0;
            y0              <= '0;
            y1              <= '0;
            x               <= '0;
            y               <= '0;
            bus.out_R       <= '0;
            bus.out_G       <= '0;
            bus.out_B       <= '0;
            bus.out_valid   <= 1'b0;
            bus.frame_done  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.out_valid  <= 1'b0;
                    bus.frame_done <= 1'b0;
                    if (bus.start) begin
                        cx       <= cx_n;
                        cy       <= cy_n;
                        x0       <= x0_n;
                        x1       <= x1_n;
                        y0       <= y0_n;
                        y1       <= y1_n;
                        x        <= '0;
                        y        <= '0;
                        bus.busy <= 1'b1;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.pixel_valid) begin
                        bus.out_valid  <= 1'b1;
                        bus.frame_done <= last_px;
                        if (on_center) begin
                            bus.out_R <= '0;
                            bus.out_G <= CMAX;
                            bus.out_B <= '0;
                        end else if (on_outline) begin
                            bus.out_R <= CMAX;
                            bus.out_G <= '0;
                            bus.out_B <= '0;
                        end else begin
                            bus.out_R <= bus.pixel_in;
                            bus.out_G <= bus.pixel_in;
                            bus.out_B <= bus.pixel_in;
                        end
                        if (x == XMAX) begin
                            x <= '0;
                            y <= y + 9'd1;
                        end else begin
                            x <= x + 9'd1;
                        end
                        if (last_px) begin
                            state <= DONE;
                        end
                    end else begin
                        bus.out_valid  <= 1'b0;
                        bus.frame_done <= 1'b0;
                    end
                end
                DONE: begin
                    bus.out_valid   <= 1'b0;
                    bus.frame_done  <= 1'b0;
                    bus.busy        <= 1'b0;
                    bus.frame_count <= bus.frame_count + 8'd1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
